// File: rtl/dwt_vertical_haar.sv
// Vertical (column) stage of the 2-D Haar DWT: buffers even rows of row-pass L/H
// coefficients and combines them with the following odd row into LL/LH/HL/HH sub-bands.
module dwt_vertical_haar #(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 30,
    parameter int DW     = 9
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic            VSYNC,
    input  logic            HSYNC,
    input  logic [DW-1:0]   DATA_R_L,
    input  logic [DW-1:0]   DATA_G_L,
    input  logic [DW-1:0]   DATA_B_L,
    input  logic [DW-1:0]   DATA_R_H,
    input  logic [DW-1:0]   DATA_G_H,
    input  logic [DW-1:0]   DATA_B_H,
    output logic [3*DW-1:0] DATA_LL,
    output logic [3*DW-1:0] DATA_LH,
    output logic [3*DW-1:0] DATA_HL,
    output logic [3*DW-1:0] DATA_HH,
    output logic            OUT_VALID,
    output logic [8:0]      OUT_ROW,
    output logic [8:0]      OUT_COL,
    output logic            FRAME_DONE,
    output logic            ROW_ERR
);
    localparam int HALF = WIDTH / 2;
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(HALF - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {ST_EVEN, ST_ODD, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q;
    logic [RW-1:0]   row_q;
    logic [6*DW-1:0] linebuf [HALF];
    logic [3*DW-1:0] in_l, in_h, buf_l, buf_h;
    logic [3*DW-1:0] ll_d, lh_d, hl_d, hh_d;
    logic            accept, col_wrap, short_row, drop, emit;

    assign in_l = {DATA_R_L, DATA_G_L, DATA_B_L};
    assign in_h = {DATA_R_H, DATA_G_H, DATA_B_H};
    assign {buf_l, buf_h} = linebuf[col_q];

    // (a +/- b) >>> 1 on DW+1 bits; the result always fits back into DW bits
    function automatic logic [DW-1:0] haar(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic sub);
        logic [DW:0] ea, eb, s;
        ea = {a[DW-1], a};
        eb = {b[DW-1], b};
        s  = sub ? (ea - eb) : (ea + eb);
        return s[DW:1];
    endfunction

    always_comb begin
        accept    = HSYNC && !VSYNC && (state_q != ST_DONE);
        drop      = HSYNC && !VSYNC && (state_q == ST_DONE);
        short_row = !HSYNC && !VSYNC && (col_q != '0);
        col_wrap  = accept && (col_q == COL_LAST);
        emit      = accept && (state_q == ST_ODD);
        state_d   = state_q;
        case (state_q)
            ST_EVEN: if (col_wrap) state_d = ST_ODD;
            ST_ODD:  if (col_wrap) state_d = (row_q == ROW_LAST) ? ST_DONE : ST_EVEN;
            ST_DONE: state_d = ST_EVEN;
            default: state_d = ST_EVEN;
        endcase
        if (VSYNC) state_d = ST_EVEN;
    end

    always_comb begin
        ll_d = '0;
        lh_d = '0;
        hl_d = '0;
        hh_d = '0;
        for (int unsigned ch = 0; ch < 3; ch++) begin
            ll_d[ch*DW +: DW] = haar(buf_l[ch*DW +: DW], in_l[ch*DW +: DW], 1'b0);
            lh_d[ch*DW +: DW] = haar(buf_l[ch*DW +: DW], in_l[ch*DW +: DW], 1'b1);
            hl_d[ch*DW +: DW] = haar(buf_h[ch*DW +: DW], in_h[ch*DW +: DW], 1'b0);
            hh_d[ch*DW +: DW] = haar(buf_h[ch*DW +: DW], in_h[ch*DW +: DW], 1'b1);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= ST_EVEN;
            col_q      <= '0;
            row_q      <= '0;
            DATA_LL    <= '0;
            DATA_LH    <= '0;
            DATA_HL    <= '0;
            DATA_HH    <= '0;
            OUT_VALID  <= 1'b0;
            OUT_ROW    <= '0;
            OUT_COL    <= '0;
            FRAME_DONE <= 1'b0;
            ROW_ERR    <= 1'b0;
        end else begin
            state_q    <= state_d;
            OUT_VALID  <= 1'b0;
            FRAME_DONE <= 1'b0;
            DATA_LL    <= '0;
            DATA_LH    <= '0;
            DATA_HL    <= '0;
            DATA_HH    <= '0;
            if (VSYNC) begin
                col_q   <= '0;
                row_q   <= '0;
                ROW_ERR <= 1'b0;
            end else begin
                if (drop || short_row) ROW_ERR <= 1'b1;
                if (short_row) begin
                    col_q <= '0;
                end else if (accept) begin
                    if (col_wrap) begin
                        col_q <= '0;
                        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                if (emit) begin
                    OUT_VALID  <= 1'b1;
                    DATA_LL    <= ll_d;
                    DATA_LH    <= lh_d;
                    DATA_HL    <= hl_d;
                    DATA_HH    <= hh_d;
                    OUT_ROW    <= 9'(row_q >> 1);
                    OUT_COL    <= 9'(col_q);
                    FRAME_DONE <= col_wrap && (row_q == ROW_LAST);
                end
            end
        end
    end

    // Even rows only write and odd rows only read, so no read/write bypass is required
    always_ff @(posedge HCLK) begin
        if (accept && state_q == ST_EVEN) linebuf[col_q] <= {in_l, in_h};
    end
endmodule
